// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BI;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BO;

    modport master (
        output START, A, B, BI,
        input  BUSY, DONE, D, BO
    );

    modport slave (
        input  START, A, B, BI,
        output BUSY, DONE, D, BO
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor, D = A - B - BI mod 2^WIDTH
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic               CLK,
    input logic               RST,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             diff_bit;
    logic             borrow_next;

    always_comb begin
        diff_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
        borrow_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    sa_d    = bus.A;
                    sb_d    = bus.B;
                    br_d    = bus.BI;
                    sd_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = {diff_bit, sd_q[WIDTH-1:1]};
                br_d  = borrow_next;
                cnt_d = cnt_q + 1'b1;
                // The last bit lands in the visible result on the same edge it is computed.
                if (cnt_q == LAST_BIT) begin
                    d_d     = {diff_bit, sd_q[WIDTH-1:1]};
                    bo_d    = borrow_next;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.D    = d_q;
    assign bus.BO   = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [W:0] sb_q[$];
    logic [W-1:0] last_d = '0;
    logic         last_bo = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input int a, input int b, input int bi);
        logic [31:0] diff;
        logic        borrow;
        diff   = 32'(a - b - bi);
        borrow = (a < b + bi);
        return {borrow, diff[W-1:0]};
    endfunction

    // Results are compared when DONE pulses; between pulses D/BO must hold.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (rst) begin
            last_d  = '0;
            last_bo = 1'b0;
        end else if (bus.DONE) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp = sb_q.pop_front();
                check("d", 32'(bus.D), 32'(exp[W-1:0]));
                check("bo", 32'(bus.BO), 32'(exp[W]));
            end
            last_d  = bus.D;
            last_bo = bus.BO;
        end else begin
            check("d_hold", 32'(bus.D), 32'(last_d));
            check("bo_hold", 32'(bus.BO), 32'(last_bo));
        end
    end

    task automatic run_op(input int a, input int b, input int bi);
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        bus.START = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.BI    = bi[0];
        sb_q.push_back(model(a, b, bi));
        @(posedge clk);
        #1 bus.START = 1'b0;
        bus.A  = W'($urandom);
        bus.B  = W'($urandom);
        bus.BI = 1'($urandom);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.DONE) begin
                seen = 1'b1;
                break;
            end
            if (bus.BUSY) busy_cycles++;
        end
        check("done_seen", 32'(seen), 1);
        check("busy_cycles", 32'(busy_cycles), W);
        @(negedge clk);
        check("idle_after_fin", 32'({bus.BUSY, bus.DONE}), 0);
    endtask

    initial begin
        int done_edges[$];

        rst       = 1'b1;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.BI    = 1'b0;
        #12;
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_done", 32'(bus.DONE), 0);
        check("rst_d", 32'(bus.D), 0);
        check("rst_bo", 32'(bus.BO), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(9, 3, 0);
        run_op(3, 9, 0);
        run_op(0, 0, 1);
        run_op(15, 15, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    run_op(a, b, bi);

        // START pulses while busy and in FIN must be ignored.
        @(negedge clk);
        bus.START = 1'b1; bus.A = 4'd7; bus.B = 4'd2; bus.BI = 1'b0;
        sb_q.push_back(model(7, 2, 0));
        @(posedge clk);
        #1 bus.START = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.START = 1'b1; bus.A = 4'd1; bus.B = 4'd1;
        @(posedge clk);
        #1 bus.START = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("fin_after_busy_start", 32'(bus.DONE), 1);
        bus.START = 1'b1;
        @(posedge clk);
        #1 bus.START = 1'b0;
        repeat (10) @(negedge clk);
        run_op(1, 1, 0);

        // Reset between edges 2 and 3 aborts the operation without a DONE.
        @(negedge clk);
        bus.START = 1'b1; bus.A = 4'd12; bus.B = 4'd5; bus.BI = 1'b0;
        @(posedge clk);
        #1 bus.START = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.BUSY), 0);
        check("midrst_done", 32'(bus.DONE), 0);
        check("midrst_d", 32'(bus.D), 0);
        check("midrst_bo", 32'(bus.BO), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(12, 5, 0);

        // Held START restarts on every IDLE edge: DONE after edges 4, 10, 16.
        for (int i = 0; i < 3; i++) sb_q.push_back(model(8, 1, 0));
        @(negedge clk);
        bus.START = 1'b1; bus.A = 4'd8; bus.B = 4'd1; bus.BI = 1'b0;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.DONE) done_edges.push_back(e);
        end
        bus.START = 1'b0;
        check("held_done_count", 32'(done_edges.size()), 3);
        if (done_edges.size() == 3) begin
            check("held_edge0", 32'(done_edges[0]), 4);
            check("held_edge1", 32'(done_edges[1]), 10);
            check("held_edge2", 32'(done_edges[2]), 16);
        end
        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor. It computes D = A − B − BI modulo 2^WIDTH and returns the final borrow on BO. Internally it uses a single full-subtractor cell and one borrow flip-flop, iterated over WIDTH clock cycles. It is the inverse of the lab01 full-adder datapath: it recovers an operand from a sum. It sits as a self-checking arithmetic unit next to the adder in the lab designs.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2).

- CLK  input  1  rising-edge clock; the block's only clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request to begin; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- BI  input  1  borrow-in; captured on the accepting edge.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when D/BO are updated.
- D  output  WIDTH  difference; registered, held until the next completion.
- BO  output  1  final borrow; registered, held until the next completion.

## Operation
- Internal state:
  - FSM with states IDLE, SHIFT, FIN.
  - Shift registers SA and SB (WIDTH bits each).
  - Result shift register SD (WIDTH bits).
  - Borrow flip-flop BR.
  - Bit counter CNT (ceil(log2(WIDTH+1)) bits).
- IDLE:
  - START=1 → load SA=A, SB=B, BR=BI, CNT=0, SD=0; go to SHIFT.
  - START=0 → stay.
- SHIFT, on every edge:
  - d = SA[0] ^ SB[0] ^ BR.
  - BR ← (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & BR).
  - SA and SB shift right by one.
  - SD ← {d, SD[WIDTH-1:1]}.
  - CNT ← CNT+1.
- Leaving SHIFT:
  - On the edge where CNT = WIDTH−1, the last bit is processed and the FSM goes to FIN.
  - On that same edge, D ← final SD value (including that bit) and BO ← final BR.
- FIN: lasts exactly one cycle, then goes to IDLE unconditionally.
- Output decode:
  - BUSY = (state == SHIFT).
  - DONE = (state == FIN).
- START handling:
  - START is ignored in SHIFT and FIN; there is no queueing.
  - A, B and BI may change freely after the accepting edge.
- Arithmetic: the result equals (A − B − BI) mod 2^WIDTH. BO=1 exactly when A < B + BI (unsigned).
- D and BO change only on the completion edge or on reset. They never show partial results.
- Reset:
  - RST=1 at any time, including mid-SHIFT, forces IDLE immediately, with no clock edge needed.
  - All registers clear: BUSY=0, DONE=0, D=0, BO=0, CNT=0, BR=0.
  - The interrupted operation is discarded and produces no DONE.
  - START is sampled again on the first edge after RST deasserts.

## Timing
- Reset values: BUSY=0, DONE=0, D=0, BO=0.
- Accepting edge is edge 0 (START=1, state IDLE).
- BUSY is high from just after edge 0 through edge WIDTH.
- Edges 1..WIDTH process bits 0..WIDTH−1.
- D/BO are updated at edge WIDTH.
- DONE is high for one cycle, between edge WIDTH and edge WIDTH+1.
- Latency from the accepting edge to DONE is WIDTH cycles. For WIDTH=4, DONE is high after edge 4.
- Earliest next accept is edge WIDTH+2 (first IDLE sample). Back-to-back throughput is one result every WIDTH+2 cycles.
- If START is held high continuously, a new operation starts on every IDLE edge, using the operand values present at that edge.

## Test plan
- Basic subtract (WIDTH=4): A=9, B=3, BI=0, one START pulse → DONE after 4 edges, D=6, BO=0; BUSY high for exactly 4 cycles.
- Underflow: A=3, B=9, BI=0 → D=0xA, BO=1. A=0, B=0, BI=1 → D=0xF, BO=1. A=15, B=15, BI=0 → D=0, BO=0.
- Exhaustive: every A, B in 0..15 and BI in 0..1, each started from IDLE → every D equals (A−B−BI) mod 16 and BO equals (A < B+BI). Exactly one DONE per START. D/BO are stable between completions.
- START while busy:
  - Start A=7, B=2.
  - Pulse START with A=1, B=1 at edges 2 and the FIN cycle.
  - Required: only one DONE, D=5, BO=0.
  - The next START in IDLE with A=1, B=1 gives D=0.
- Reset mid-operation:
  - Start A=12, B=5, assert RST between edges 2 and 3.
  - Required: BUSY=0 with no clock edge, D=0, BO=0, and no DONE.
  - After release, A=12, B=5 → D=7, BO=0.
- Held START: START=1 permanently with A=8, B=1 → DONE pulses at edges 4, 10, 16 (period 6). D=7 each time.
